// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-FIFO types and constants.
// Contents:
//   UART_RX_FIFO_DEPTH : default number of receive FIFO entries
//   UART_DWIDTH        : default character width
//   THR_*              : thr_sel encodings for the receive threshold interrupt
//   rx_entry_t         : packed FIFO entry {parity_err, frame_err, data}
package uart_pkg;
    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int UART_DWIDTH = 8;
    localparam logic [1:0] THR_ONE = 2'b00;
    localparam logic [1:0] THR_QUARTER = 2'b01;
    localparam logic [1:0] THR_HALF = 2'b10;
    localparam logic [1:0] THR_NEAR_FULL = 2'b11;
    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic [UART_DWIDTH-1:0] data;
    } rx_entry_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port.
// Ports:
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from i_raddr)
// Contents are never reset.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through receive FIFO with per-entry error tags and sticky overrun.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   wr_en, wdata                : write strobe and received character
//   frame_err_in, parity_err_in : error status of the character being written
//   rd_en                       : pop head entry
//   flush                       : discard all entries, clear overrun
//   ovr_clr                     : clear sticky overrun
//   rdata, frame_err, parity_err: head entry (valid while !empty)
//   empty, fifo_nfull, count    : occupancy status
//   overrun                     : sticky, set when a write is dropped on a full FIFO
//   thr_sel, rx_thr_irq         : occupancy threshold interrupt (only with RX_FIFO_THRESHOLD_EN)
// Build option: define RX_FIFO_THRESHOLD_EN to add the threshold interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int DWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DWIDTH-1:0]      wdata,
    input  logic                   frame_err_in,
    input  logic                   parity_err_in,
    input  logic                   rd_en,
    input  logic                   flush,
    input  logic                   ovr_clr,
    output logic [DWIDTH-1:0]      rdata,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   empty,
    output logic                   fifo_nfull,
    output logic [$clog2(DEPTH):0] count,
`ifdef RX_FIFO_THRESHOLD_EN
    input  logic [1:0]             thr_sel,
    output logic                   rx_thr_irq,
`endif
    output logic                   overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic r_ovr;
    logic w_full, w_empty, w_wr_acc, w_rd_acc, w_drop;
    logic [DWIDTH+1:0] w_head;
    assign w_full = r_count == CW'(DEPTH);
    assign w_empty = r_count == '0;
    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    assign w_wr_acc = wr_en && (!w_full || rd_en);
    assign w_rd_acc = rd_en && !w_empty;
    assign w_drop = wr_en && w_full && !rd_en;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_count <= '0;
            r_ovr <= 1'b0;
        end else begin
            r_wptr <= r_wptr + AW'(w_wr_acc);
            r_rptr <= r_rptr + AW'(w_rd_acc);
            r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
            r_ovr <= w_drop ? 1'b1 : ovr_clr ? 1'b0 : r_ovr;
        end
    end
    // Entry layout matches rx_entry_t: {parity_err, frame_err, data}.
    uart_fifo_mem #(.DEPTH(DEPTH), .WIDTH(DWIDTH + 2)) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc && !rst && !flush),
        .i_waddr (r_wptr),
        .i_wdata ({parity_err_in, frame_err_in, wdata}),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );
    assign {parity_err, frame_err, rdata} = w_head;
    assign empty = w_empty;
    assign fifo_nfull = w_full;
    assign count = r_count;
    assign overrun = r_ovr;
`ifdef RX_FIFO_THRESHOLD_EN
    logic [CW-1:0] w_level;
    always_comb begin
        w_level = thr_sel == THR_ONE     ? CW'(1)
                : thr_sel == THR_QUARTER ? CW'(DEPTH / 4)
                : thr_sel == THR_HALF    ? CW'(DEPTH / 2)
                :                          CW'(DEPTH - 2);
    end
    assign rx_thr_irq = r_count >= w_level;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-based self-checking bench for uart_rx_fifo (DEPTH=16, DWIDTH=8).
module tb_uart_rx_fifo;
    import uart_pkg::*;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic rst, wr_en, frame_err_in, parity_err_in, rd_en, flush, ovr_clr;
    logic [7:0] wdata, rdata;
    logic frame_err, parity_err, empty, fifo_nfull, overrun;
    logic [4:0] count;
`ifdef RX_FIFO_THRESHOLD_EN
    logic [1:0] thr_sel;
    logic rx_thr_irq;
`endif
    int n_tests = 0;
    int n_fail = 0;
    rx_entry_t q[$];
    logic m_ovr = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .DWIDTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata),
        .frame_err_in(frame_err_in), .parity_err_in(parity_err_in),
        .rd_en(rd_en), .flush(flush), .ovr_clr(ovr_clr),
        .rdata(rdata), .frame_err(frame_err), .parity_err(parity_err),
        .empty(empty), .fifo_nfull(fifo_nfull), .count(count),
`ifdef RX_FIFO_THRESHOLD_EN
        .thr_sel(thr_sel), .rx_thr_irq(rx_thr_irq),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // One clock edge of stimulus; the reference model (queue + overrun) is updated alongside.
    task automatic drive(input logic wr, input logic rd, input logic [7:0] d,
                         input logic fe, input logic pe, input logic oc,
                         input logic fl, input logic rs);
        bit wacc, racc, drop;
        rx_entry_t e;
        wr_en = wr; rd_en = rd; wdata = d; frame_err_in = fe; parity_err_in = pe;
        ovr_clr = oc; flush = fl; rst = rs;
        wacc = wr && (q.size() < DEPTH || rd);
        racc = rd && q.size() > 0;
        drop = wr && q.size() == DEPTH && !rd;
        e.parity_err = pe; e.frame_err = fe; e.data = d;
        @(posedge clk); #1;
        if (rs || fl) begin
            q.delete();
            m_ovr = 1'b0;
        end else begin
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(e);
            m_ovr = drop ? 1'b1 : oc ? 1'b0 : m_ovr;
        end
        wr_en = 0; rd_en = 0; ovr_clr = 0; flush = 0; rst = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        drive(1, 0, d, 0, 0, 0, 0, 0);
    endtask

    task automatic rd();
        drive(0, 1, 8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 0, 8'h00, 0, 0, 0, 0, 1);
        drive(0, 0, 8'h00, 0, 0, 0, 0, 1);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (fifo_nfull !== 1'b0) begin n_fail++; $display("FAIL reset_nfull got %b exp 0", fifo_nfull); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_basic();
        wr(8'h41);
        n_tests++; if (rdata !== q[0].data || rdata !== 8'h41) begin n_fail++; $display("FAIL basic_first got %h exp 41", rdata); end
        n_tests++; if (count !== 5'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL basic_cnt1 got %0d/%b exp 1/0", count, empty); end
        wr(8'h42);
        rd();
        n_tests++; if (rdata !== q[0].data || rdata !== 8'h42) begin n_fail++; $display("FAIL basic_second got %h exp 42", rdata); end
        rd();
        n_tests++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL basic_drained got %b/%0d exp 1/0", empty, count); end
        rd();
        n_tests++; if (count !== 5'd0 || overrun !== 1'b0) begin n_fail++; $display("FAIL underflow got %0d/%b exp 0/0", count, overrun); end
        drive(1, 1, 8'h77, 0, 0, 0, 0, 0);
        n_tests++; if (count !== 5'd1 || rdata !== 8'h77) begin n_fail++; $display("FAIL empty_wr_rd got %0d/%h exp 1/77", count, rdata); end
        rd();
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < 16; i++) wr(8'(i));
        n_tests++; if (fifo_nfull !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL full got %b/%0d exp 1/16", fifo_nfull, count); end
        wr(8'hAA);
        n_tests++; if (overrun !== m_ovr || overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b exp 1", overrun); end
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL overrun_count got %0d exp 16", count); end
        drive(1, 0, 8'hAB, 0, 0, 1, 0, 0);
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (rdata !== q[0].data) begin n_fail++; $display("FAIL drain_%0d got %h exp %h", i, rdata, q[0].data); end
            rd();
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", empty); end
        drive(0, 0, 8'h00, 0, 0, 1, 0, 0);
        n_tests++; if (overrun !== m_ovr || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got %b exp 0", overrun); end
    endtask

    task automatic test_full_simul();
        logic [7:0] last;
        for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
        drive(1, 1, 8'h55, 0, 0, 0, 0, 0);
        n_tests++; if (count !== 5'd16 || overrun !== 1'b0) begin n_fail++; $display("FAIL simul_full got %0d/%b exp 16/0", count, overrun); end
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (rdata !== q[0].data) begin n_fail++; $display("FAIL simul_drain_%0d got %h exp %h", i, rdata, q[0].data); end
            last = rdata;
            rd();
        end
        n_tests++; if (last !== 8'h55) begin n_fail++; $display("FAIL simul_last got %h exp 55", last); end
    endtask

    task automatic test_err_tags();
        drive(1, 0, 8'h33, 1, 0, 0, 0, 0);
        drive(1, 0, 8'h34, 0, 1, 0, 0, 0);
        n_tests++; if ({parity_err, frame_err, rdata} !== q[0] || frame_err !== 1'b1 || parity_err !== 1'b0)
            begin n_fail++; $display("FAIL tag_frame got %b%b/%h exp 01/33", parity_err, frame_err, rdata); end
        rd();
        n_tests++; if ({parity_err, frame_err, rdata} !== q[0] || parity_err !== 1'b1 || frame_err !== 1'b0)
            begin n_fail++; $display("FAIL tag_parity got %b%b/%h exp 10/34", parity_err, frame_err, rdata); end
        rd();
    endtask

    task automatic test_flush_rst();
        for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
        drive(1, 0, 8'h99, 0, 0, 0, 1, 0);
        n_tests++; if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL flush got %0d/%b/%b exp 0/1/0", count, empty, overrun); end
        for (int i = 0; i < 17; i++) wr(8'(i));
        drive(0, 0, 8'h00, 0, 0, 0, 1, 0);
        n_tests++; if (overrun !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL flush_ovr got %b/%0d exp 0/0", overrun, count); end
        for (int i = 0; i < 3; i++) wr(8'(8'h70 + i));
        drive(1, 0, 8'h73, 0, 0, 0, 0, 1);
        n_tests++; if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || fifo_nfull !== 1'b0)
            begin n_fail++; $display("FAIL rst_burst got %0d/%b/%b exp 0/1/0", count, empty, overrun); end
        wr(8'h5A);
        n_tests++; if (rdata !== q[0].data || count !== 5'd1) begin n_fail++; $display("FAIL post_rst got %h/%0d exp %h/1", rdata, count, q[0].data); end
        rd();
    endtask

`ifdef RX_FIFO_THRESHOLD_EN
    task automatic test_threshold();
        thr_sel = THR_HALF;
        for (int i = 0; i < 7; i++) wr(8'(i));
        n_tests++; if (rx_thr_irq !== 1'b0) begin n_fail++; $display("FAIL thr_7 got %b exp 0", rx_thr_irq); end
        wr(8'h07);
        n_tests++; if (rx_thr_irq !== 1'b1) begin n_fail++; $display("FAIL thr_8 got %b exp 1", rx_thr_irq); end
        rd();
        n_tests++; if (rx_thr_irq !== 1'b0) begin n_fail++; $display("FAIL thr_back got %b exp 0", rx_thr_irq); end
        drive(0, 0, 8'h00, 0, 0, 0, 1, 0);
    endtask
`endif

    initial begin
        rst = 1; wr_en = 0; rd_en = 0; flush = 0; ovr_clr = 0;
        wdata = 0; frame_err_in = 0; parity_err_in = 0;
`ifdef RX_FIFO_THRESHOLD_EN
        thr_sel = THR_ONE;
`endif
        test_reset();
        test_basic();
        test_full_overrun();
        test_full_simul();
        test_err_tags();
        test_flush_rst();
`ifdef RX_FIFO_THRESHOLD_EN
        test_threshold();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
